uart_rx_monitor: RTL

Asynchronous 8N1 serial receiver that decodes the serial stream the core emits on `uart_tx`, mainly the diagnostic ROM's console output. It sits in the simulation top and in board tops next to the core. Received bytes go out through a one-entry valid/ready holding register, so a bench checker or an on-board debug FIFO can consume them. Line errors are reported as single-cycle status pulses.

---
 rtl/uart_rx_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 serial receiver for the core's uart_tx console stream.
// Decoded bytes are presented through a one-entry valid/ready holding register.
// Framing errors, breaks and overruns are reported as single-cycle pulses.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 1667
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       break_det,
    output logic       overrun,
    output logic       busy
);

    // Each sample point restarts the counter, so every bit interval is exactly N
    // cycles and no rounding can accumulate across the frame.
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_meta_p0;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        half_hit;
    logic        full_hit;
    logic        stop_sample;
    logic        byte_good;
    logic        byte_bad;
    logic        load;

    assign half_hit    = (cnt == HALF_M1);
    assign full_hit    = (cnt == FULL_M1);
    assign stop_sample = (state == STOP) && full_hit;
    assign byte_good   = stop_sample && rx_s;
    assign byte_bad    = stop_sample && !rx_s;
    // A good byte loads if the register is empty or is being drained this cycle.
    assign load        = byte_good && (!valid || ready);
    assign busy        = (state != IDLE);

    // Two-flop synchronizer; idles high so reset cannot fake a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= rxd;
            rx_s       <= rx_meta_p0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (half_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (full_hit && (bit_idx == 3'd7)) state_nxt = STOP;
            STOP:      if (full_hit) state_nxt = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Bit timing counter and bit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            if ((state == IDLE) || (state == WAIT_HIGH)) begin
                cnt <= '0;
            end else if (((state == START) && half_hit) ||
                         (((state == DATA) || (state == STOP)) && full_hit)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            if ((state == START) && half_hit) begin
                bit_idx <= '0;
            end else if ((state == DATA) && full_hit) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Receive shift register, LSB arrives first.
    always_ff @(posedge clk) begin
        if ((state == DATA) && full_hit) begin
            shreg <= {rx_s, shreg[7:1]};
        end
    end

    // Holding register and status pulses, registered from the stop-sample cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            frame_err <= byte_bad;
            break_det <= byte_bad && (shreg == 8'h00);
            overrun   <= byte_good && valid && !ready;
        end
    end

endmodule
